// File: rtl/median_filter_3x3_if.sv
// Column stream into the 3x3 median stage and the filtered pixel stream out of it.
interface median_filter_3x3_if #(
    parameter int unsigned CH_W = 8,
    parameter int unsigned CH_N = 3
);
    logic [10:0]          img_width;
    logic                 valid_i;
    logic [CH_W*CH_N-1:0] prev_line_i;
    logic [CH_W*CH_N-1:0] cur_line_i;
    logic [CH_W*CH_N-1:0] next_line_i;
    logic                 valid_o;
    logic [CH_W*CH_N-1:0] pixel_o;
    logic                 eol_o;

    modport master (
        output img_width, valid_i, prev_line_i, cur_line_i, next_line_i,
        input  valid_o, pixel_o, eol_o
    );

    modport slave (
        input  img_width, valid_i, prev_line_i, cur_line_i, next_line_i,
        output valid_o, pixel_o, eol_o
    );
endinterface

// File: rtl/median_filter_3x3.sv
// 3x3 per-channel median over line-buffer column triples, with left/right edge
// replication and a one-cycle flush window for the last column of each line.
module median_filter_3x3 #(
    parameter int unsigned CH_W = 8,
    parameter int unsigned CH_N = 3
) (
    input logic                clk,
    input logic                reset_n,
    median_filter_3x3_if.slave bus
);
    localparam int unsigned PIX_W = CH_W * CH_N;

    typedef logic [PIX_W-1:0] pix_t;
    typedef logic [CH_W-1:0]  ch_t;

    function automatic ch_t chan(input pix_t p, input int unsigned k);
        return p[k*CH_W +: CH_W];
    endfunction

    function automatic ch_t min2(input ch_t a, input ch_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic ch_t max2(input ch_t a, input ch_t b);
        return (a < b) ? b : a;
    endfunction

    function automatic ch_t med3(input ch_t a, input ch_t b, input ch_t c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

    // Column tracking and window source registers
    logic [10:0] col_q;
    logic [10:0] width_q;
    logic [10:0] eff_width;
    logic        last_col;
    logic        flush_q;
    pix_t        l_q    [3];
    pix_t        c_q    [3];
    pix_t        in_col [3];

    // Window issue and pipeline stages
    logic        win_v;
    logic        win_eol;
    pix_t        win      [3][3];
    logic        s1_v, s1_eol;
    pix_t        s1_win   [3][3];
    logic        s2_v, s2_eol;
    pix_t        s2_min_d [3], s2_mid_d [3], s2_max_d [3];
    pix_t        s2_min_q [3], s2_mid_q [3], s2_max_q [3];
    logic        s3_v, s3_eol;
    pix_t        s3_a_d, s3_b_d, s3_c_d;
    pix_t        s3_a_q, s3_b_q, s3_c_q;
    pix_t        s4_d;

    assign in_col[0] = bus.prev_line_i;
    assign in_col[1] = bus.cur_line_i;
    assign in_col[2] = bus.next_line_i;

    // The width in force for column 0 is the live input, since it is latched there.
    assign eff_width = (col_q == '0) ? bus.img_width : width_q;
    assign last_col  = (col_q == eff_width - 11'd1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            col_q   <= '0;
            width_q <= '0;
            flush_q <= 1'b0;
            for (int unsigned r = 0; r < 3; r++) begin
                l_q[r] <= '0;
                c_q[r] <= '0;
            end
        end else begin
            flush_q <= bus.valid_i && last_col;
            if (bus.valid_i) begin
                col_q <= last_col ? '0 : col_q + 11'd1;
                if (col_q == '0) begin
                    width_q <= bus.img_width;
                    for (int unsigned r = 0; r < 3; r++) begin
                        l_q[r] <= in_col[r];
                        c_q[r] <= in_col[r];
                    end
                end else begin
                    for (int unsigned r = 0; r < 3; r++) begin
                        l_q[r] <= c_q[r];
                        c_q[r] <= in_col[r];
                    end
                end
            end
        end
    end

    // A flush never collides with an interior window: the column after the last is always col 0.
    always_comb begin
        win_v   = 1'b0;
        win_eol = 1'b0;
        for (int unsigned c = 0; c < 3; c++) begin
            for (int unsigned r = 0; r < 3; r++) begin
                win[c][r] = '0;
            end
        end
        if (flush_q) begin
            win_v   = 1'b1;
            win_eol = 1'b1;
            for (int unsigned r = 0; r < 3; r++) begin
                win[0][r] = l_q[r];
                win[1][r] = c_q[r];
                win[2][r] = c_q[r];
            end
        end else if (bus.valid_i && col_q != '0) begin
            win_v = 1'b1;
            for (int unsigned r = 0; r < 3; r++) begin
                win[0][r] = l_q[r];
                win[1][r] = c_q[r];
                win[2][r] = in_col[r];
            end
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < 3; c++) begin
            s2_min_d[c] = '0;
            s2_mid_d[c] = '0;
            s2_max_d[c] = '0;
            for (int unsigned k = 0; k < CH_N; k++) begin
                s2_min_d[c][k*CH_W +: CH_W] = min2(min2(chan(s1_win[c][0], k), chan(s1_win[c][1], k)),
                                                   chan(s1_win[c][2], k));
                s2_mid_d[c][k*CH_W +: CH_W] = med3(chan(s1_win[c][0], k), chan(s1_win[c][1], k),
                                                   chan(s1_win[c][2], k));
                s2_max_d[c][k*CH_W +: CH_W] = max2(max2(chan(s1_win[c][0], k), chan(s1_win[c][1], k)),
                                                   chan(s1_win[c][2], k));
            end
        end
    end

    always_comb begin
        s3_a_d = '0;
        s3_b_d = '0;
        s3_c_d = '0;
        s4_d   = '0;
        for (int unsigned k = 0; k < CH_N; k++) begin
            s3_a_d[k*CH_W +: CH_W] = max2(max2(chan(s2_min_q[0], k), chan(s2_min_q[1], k)), chan(s2_min_q[2], k));
            s3_b_d[k*CH_W +: CH_W] = med3(chan(s2_mid_q[0], k), chan(s2_mid_q[1], k), chan(s2_mid_q[2], k));
            s3_c_d[k*CH_W +: CH_W] = min2(min2(chan(s2_max_q[0], k), chan(s2_max_q[1], k)), chan(s2_max_q[2], k));
            s4_d[k*CH_W +: CH_W]   = med3(chan(s3_a_q, k), chan(s3_b_q, k), chan(s3_c_q, k));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_v        <= 1'b0;
            s1_eol      <= 1'b0;
            s2_v        <= 1'b0;
            s2_eol      <= 1'b0;
            s3_v        <= 1'b0;
            s3_eol      <= 1'b0;
            s3_a_q      <= '0;
            s3_b_q      <= '0;
            s3_c_q      <= '0;
            bus.valid_o <= 1'b0;
            bus.eol_o   <= 1'b0;
            bus.pixel_o <= '0;
            for (int unsigned c = 0; c < 3; c++) begin
                s2_min_q[c] <= '0;
                s2_mid_q[c] <= '0;
                s2_max_q[c] <= '0;
                for (int unsigned r = 0; r < 3; r++) begin
                    s1_win[c][r] <= '0;
                end
            end
        end else begin
            s1_v        <= win_v;
            s1_eol      <= win_eol;
            s2_v        <= s1_v;
            s2_eol      <= s1_eol;
            s3_v        <= s2_v;
            s3_eol      <= s2_eol;
            bus.valid_o <= s3_v;
            bus.eol_o   <= s3_v && s3_eol;
            if (win_v) begin
                for (int unsigned c = 0; c < 3; c++) begin
                    for (int unsigned r = 0; r < 3; r++) begin
                        s1_win[c][r] <= win[c][r];
                    end
                end
            end
            if (s1_v) begin
                for (int unsigned c = 0; c < 3; c++) begin
                    s2_min_q[c] <= s2_min_d[c];
                    s2_mid_q[c] <= s2_mid_d[c];
                    s2_max_q[c] <= s2_max_d[c];
                end
            end
            if (s2_v) begin
                s3_a_q <= s3_a_d;
                s3_b_q <= s3_b_d;
                s3_c_q <= s3_c_d;
            end
            if (s3_v) begin
                bus.pixel_o <= s4_d;
            end
        end
    end
endmodule

// File: tb/tb_median_filter_3x3.sv
// Directed bench for median_filter_3x3: expected pixels are queued as lines are
// driven and compared, in order, whenever the filter emits a pixel.
module tb_median_filter_3x3;
    localparam int unsigned CH_W = 8;
    localparam int unsigned CH_N = 3;

    typedef logic [CH_W*CH_N-1:0] pix_t;
    typedef struct packed {
        logic eol;
        pix_t pix;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   last_in_cyc = 0;
    int   last_eol_cyc = 0;

    exp_t exp_q[$];
    int   out_cycs[$];
    pix_t lp [16];
    pix_t lc [16];
    pix_t ln [16];

    median_filter_3x3_if #(.CH_W(CH_W), .CH_N(CH_N)) bus ();

    median_filter_3x3 #(.CH_W(CH_W), .CH_N(CH_N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: sort all nine replicated window values per channel, take the 5th.
    function automatic pix_t med9(input int w, input int x);
        pix_t       r;
        int         cs [3];
        logic [7:0] v  [9];
        logic [7:0] t;
        int         n;
        r     = '0;
        cs[0] = (x > 0) ? x - 1 : 0;
        cs[1] = x;
        cs[2] = (x < w - 1) ? x + 1 : w - 1;
        for (int k = 0; k < CH_N; k++) begin
            n = 0;
            for (int j = 0; j < 3; j++) begin
                v[n] = lp[cs[j]][k*CH_W +: CH_W]; n++;
                v[n] = lc[cs[j]][k*CH_W +: CH_W]; n++;
                v[n] = ln[cs[j]][k*CH_W +: CH_W]; n++;
            end
            for (int a = 0; a < 9; a++) begin
                for (int b = 0; b < 8 - a; b++) begin
                    if (v[b] > v[b+1]) begin
                        t = v[b]; v[b] = v[b+1]; v[b+1] = t;
                    end
                end
            end
            r[k*CH_W +: CH_W] = v[4];
        end
        return r;
    endfunction

    task automatic send_line(input int w, input int gap, input bit model);
        if (model) begin
            for (int x = 0; x < w; x++) exp_q.push_back('{eol: (x == w - 1), pix: med9(w, x)});
        end
        for (int x = 0; x < w; x++) begin
            @(negedge clk);
            bus.valid_i     = 1'b1;
            bus.prev_line_i = lp[x];
            bus.cur_line_i  = lc[x];
            bus.next_line_i = ln[x];
            last_in_cyc     = cyc + 1;
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                bus.valid_i = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bus.valid_i = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.valid_o === 1'b1) begin
            out_cycs.push_back(cyc);
            check("output_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("pixel", bus.pixel_o, e.pix);
                check("eol", bus.eol_o, e.eol);
            end
            if (bus.eol_o === 1'b1) last_eol_cyc = cyc;
        end
    end

    initial begin
        reset_n         = 1'b0;
        bus.valid_i     = 1'b0;
        bus.img_width   = 11'd3;
        bus.prev_line_i = '0;
        bus.cur_line_i  = '0;
        bus.next_line_i = '0;

        // Reset held with valid_i toggling
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("reset_valid_o", bus.valid_o, 0);
            check("reset_pixel_o", bus.pixel_o, 0);
            check("reset_eol_o", bus.eol_o, 0);
            bus.valid_i     = ~bus.valid_i;
            bus.cur_line_i  = pix_t'($urandom);
        end
        @(negedge clk);
        reset_n     = 1'b1;
        bus.valid_i = 1'b0;
        idle(4);

        // W=3 edge replication, hand-computed expectations
        for (int x = 0; x < 3; x++) begin
            lp[x] = {8'(x + 1), 16'h0};
            lc[x] = {8'(x + 4), 16'h0};
            ln[x] = {8'(x + 7), 16'h0};
        end
        bus.img_width = 11'd3;
        exp_q.push_back('{eol: 1'b0, pix: 24'h040000});
        exp_q.push_back('{eol: 1'b0, pix: 24'h050000});
        exp_q.push_back('{eol: 1'b1, pix: 24'h060000});
        send_line(3, 0, 1'b0);
        idle(10);
        check("last_col_latency", last_eol_cyc - last_in_cyc, 4);

        // Back-to-back lines
        out_cycs.delete();
        send_line(3, 0, 1'b1);
        send_line(3, 0, 1'b1);
        idle(10);
        check("b2b_count", out_cycs.size(), 6);
        if (out_cycs.size() == 6) begin
            for (int i = 1; i < 6; i++) check("b2b_no_gap", out_cycs[i] - out_cycs[i-1], 1);
        end

        // Gapped input
        out_cycs.delete();
        send_line(3, 2, 1'b1);
        idle(10);
        check("gapped_count", out_cycs.size(), 3);

        // Impulse rejection
        bus.img_width = 11'd5;
        for (int x = 0; x < 5; x++) begin
            lp[x] = '0; lc[x] = '0; ln[x] = '0;
            exp_q.push_back('{eol: (x == 4), pix: 24'h000000});
        end
        lc[2] = 24'hFFFFFF;
        send_line(5, 0, 1'b0);
        idle(10);

        // Width 1 followed directly by a W=4 random line
        bus.img_width = 11'd1;
        lp[0] = 24'h10F020; lc[0] = 24'h805010; ln[0] = 24'h40A0FF;
        send_line(1, 0, 1'b1);
        idle(8);
        bus.img_width = 11'd4;
        for (int x = 0; x < 4; x++) begin
            lp[x] = pix_t'($urandom); lc[x] = pix_t'($urandom); ln[x] = pix_t'($urandom);
        end
        send_line(4, 0, 1'b1);
        idle(10);

        // Reset mid-line: partial line must produce nothing
        for (int x = 0; x < 4; x++) begin
            lp[x] = pix_t'($urandom); lc[x] = pix_t'($urandom); ln[x] = pix_t'($urandom);
        end
        send_line(2, 0, 1'b0);
        @(negedge clk);
        bus.valid_i = 1'b0;
        reset_n     = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        out_cycs.delete();
        send_line(4, 0, 1'b1);
        idle(12);
        check("post_reset_count", out_cycs.size(), 4);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/median_filter_3x3.md
Name: median_filter_3x3

Overview:
- Consumer end of the three-line window interface.
- Accepts column-aligned top/middle/bottom pixel streams from the line buffer. Top/bottom edge replication is already applied upstream.
- Forms a 3x3 window with left/right edge replication and outputs the per-channel median, one output pixel per input column.
- Sits between the line buffer and the output pixel stream of the median-filter datapath.

Parameters:
- CH_W, 8, bits per colour channel.
- CH_N, 3, channels per pixel. Channel k occupies bits [k*CH_W +: CH_W], so the default is R[23:16], G[15:8], B[7:0].

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset_n  in  1  reset; synchronous, active-low.
- img_width  in  11  pixels per line, 1..2047.
- valid_i  in  1  one column of three pixels present this cycle.
- prev_line_i  in  CH_W*CH_N  top-row pixel.
- cur_line_i  in  CH_W*CH_N  middle-row pixel; this row is the output row.
- next_line_i  in  CH_W*CH_N  bottom-row pixel.
- valid_o  out  1  pixel_o valid, one-cycle pulse per output pixel.
- pixel_o  out  CH_W*CH_N  median-filtered pixel.
- eol_o  out  1  high with valid_o on the last pixel of a line.

Behaviour:
- Reset (reset_n low at a clock edge):
  - valid_o, pixel_o and eol_o go to 0.
  - Column counter, window registers, flush flag and all pipeline valids are cleared.
  - Any in-flight pixels are discarded and produce no output after reset.
- No backpressure: valid_i may be high in any cycle, back-to-back or gapped. Nothing is ever dropped.
- Column counter col (11 bit):
  - Advances on each valid_i.
  - Wraps to 0 after img_width-1.
  - img_width is latched when valid_i is accepted with col==0. Changes mid-line take effect at the next line.
- Column registers L and C each hold three pixels (top/mid/bottom).
- On valid_i with col==0:
  - L <= input and C <= input (left replication).
  - No window is issued.
- On valid_i with col>0:
  - Issue window (L, C, input), centred on column col-1.
  - Then L <= C, C <= input.
- Flush cycle for the last column:
  - On valid_i with col==latched_width-1, the flush flag is set. This includes width 1, where col 0 is also the last column.
  - The cycle after that edge is unconditionally a flush cycle, which issues window (L, C, C), centred on the last column, with eol tag = 1.
  - A valid_i at col 0 in the flush cycle is legal. The flush reads the pre-edge L/C while the new line loads L/C at the same edge. No stall and no loss.
  - Width 1: flush window is (in, in, in).
- Window issue and pipeline (each stage registered, with its own valid and eol bits):
  - S1: register the 9 pixels.
  - S2: per column, per channel, sort the 3 values into min/mid/max.
  - S3: compute max of the three mins, median of the three mids, min of the three maxes.
  - S4: median of those three values gives pixel_o, and valid_o/eol_o are driven.
- Latency:
  - Window issued at edge n gives valid_o high after edge n+3.
  - For an interior column, this is 3 edges after the edge accepting column x+1.
  - For the last column, it is 4 edges after the edge accepting the last column.
- Channels are fully independent. Comparisons are unsigned. No arithmetic widening; output values are always drawn from the inputs.
- Exactly img_width outputs per line, in column order.
- Throughput is 1 pixel/clock sustained with continuous valid_i across lines.
- pixel_o holds its last value when valid_o is low.

Test Plan:
- Reset: hold reset_n=0 for 5 cycles with valid_i toggling -> valid_o=0, pixel_o=0, eol_o=0 throughout. First valid_o appears only after post-reset input.
- Edge replication, W=3, single line:
  - Stimulus R channel: prev=(1,2,3), cur=(4,5,6), next=(7,8,9); G=B=0.
  - Required outputs: pixel_o R = 4, 5, 6 in order, G=B=0.
  - eol_o only on the third output; the third output appears 4 edges after the last input.
- Back-to-back lines: W=3, valid_i continuously high for 6 cycles (2 lines) -> 6 consecutive valid_o pulses with no gap. The line-1 flush coincides with line-2 col 0. eol_o on outputs 3 and 6.
- Gapped input: same data as the W=3 case, valid_i high every third cycle -> identical values 4, 5, 6 and eol placement. Total valid_o count = 3.
- Impulse rejection: W=5, all pixels 0x000000 except cur column 2 = 0xFFFFFF -> all 5 outputs 0x000000.
- Reset mid-line: W=4, 2 columns accepted, then reset_n=0 for 1 cycle, then a full 4-column line -> exactly 4 valid_o pulses after reset with correct values. No output derived from the pre-reset columns.
